// File: rtl/io_responder_pkg.sv
// Shared constants for the IO responder: register map, STATUS layout and interrupt vector encoding.
package io_responder_pkg;

  localparam logic [3:0] IO_STATUS   = 4'd0;
  localparam logic [3:0] IO_MASK     = 4'd1;
  localparam logic [3:0] IO_PEND     = 4'd2;
  localparam logic [3:0] IO_GPIO_OUT = 4'd3;
  localparam logic [3:0] IO_GPIO_IN  = 4'd4;

  localparam int ST_FULL     = 5;
  localparam int ST_EMPTY    = 6;
  localparam int ST_RAS_CNT  = 7;
  localparam int ST_FIFO_OVF = 10;
  localparam int ST_RAS_OVF  = 11;
  localparam int ST_RAS_UNF  = 12;
  localparam int ST_IRQ      = 13;

  localparam logic [15:0] IRQ_VALID = 16'h8000;
  localparam logic [15:0] IRQ_NONE  = 16'h0000;

  // Which read-type strobe owns d_bus this cycle.
  typedef enum logic [1:0] {RD_NONE, RD_REG, RD_RAS, RD_INTS} rd_sel_e;

  function automatic logic [2:0] lowest_irq(input logic [7:0] v);
    lowest_irq = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_irq = 3'(i);
    end
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU-side IO strobe group. Strobes are single-cycle commands sampled at the rising edge;
// there is no ready: the responder always accepts. bus_drive is high while the responder owns d_bus.
interface io_responder_if;
  logic        io_read;
  logic        io_write;
  logic        io_push;
  logic        io_ints;
  logic        io_store_retaddr;
  logic        io_read_retaddr;
  logic [15:0] d_addr;
  logic        bus_drive;

  modport master (
    output io_read, io_write, io_push, io_ints, io_store_retaddr, io_read_retaddr, d_addr,
    input  bus_drive
  );

  modport slave (
    input  io_read, io_write, io_push, io_ints, io_store_retaddr, io_read_retaddr, d_addr,
    output bus_drive
  );
endinterface

// File: rtl/io_responder_sync_fifo.sv
// Synchronous FIFO with registered head word; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
  logic             push_ok, pop_ok;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign pop_ok      = pop & ~empty;
  assign push_ok     = push & (~full | pop_ok);
  assign rd_ptr_next = rd_ptr + AW'(pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      count  <= count + CW'(push_ok) - CW'(pop_ok);
      // Bypass when the word being written becomes the new head.
      rdata  <= (push_ok && (wr_ptr == rd_ptr_next)) ? wdata : mem[rd_ptr_next];
    end
  end
endmodule

// File: rtl/io_responder.sv
// IO responder: register file, outbound push FIFO, 8-line interrupt controller and return-address stack.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RAS_DEPTH  = 4,
  parameter int NUM_IRQ    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  io_responder_if.slave      bus,
  inout  wire  [15:0]        d_bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_pending,
  output logic [15:0]        dev_data,
  output logic               dev_valid,
  input  logic               dev_ready,
  output logic [15:0]        gpio_out,
  input  logic [15:0]        gpio_in
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int RAW = $clog2(RAS_DEPTH);
  localparam int RCW = RAW + 1;

  rd_sel_e              rd_sel;
  logic                 drive;
  logic [15:0]          rd_data, reg_data, status;
  logic [3:0]           addr;
  logic                 unused_addr_bits;

  logic [NUM_IRQ-1:0]   sync1, sync2, sync3;
  logic [7:0]           mask, pend, active, pend_set, pend_clr;
  logic [2:0]           vec;
  logic [15:0]          gpio_in_q;
  logic                 fifo_ovf, ras_ovf, ras_unf;
  logic                 wr_status, wr_mask, wr_pend, wr_gpio;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [FCW-1:0]       fifo_count;

  logic [15:0]          ras_mem [RAS_DEPTH];
  logic [RAW-1:0]       ras_sp, ras_top_idx;
  logic [RCW-1:0]       ras_count;
  logic                 ras_full, ras_empty, ras_pop, ras_pop_ok;
  logic [15:0]          ras_top;

  assign addr             = bus.d_addr[3:0];
  assign unused_addr_bits = ^bus.d_addr[15:4];

  always_comb begin
    rd_sel = RD_NONE;
    if (bus.io_ints)              rd_sel = RD_INTS;
    else if (bus.io_read_retaddr) rd_sel = RD_RAS;
    else if (bus.io_read)         rd_sel = RD_REG;
  end

  assign drive         = (rd_sel != RD_NONE);
  assign bus.bus_drive = drive;
  assign d_bus         = drive ? rd_data : 16'hzzzz;

  assign active   = pend & mask;
  assign vec      = lowest_irq(active);
  assign pend_set = sync2 & ~sync3;
  assign pend_clr = ((rd_sel == RD_INTS && |active) ? (8'b1 << vec) : 8'h00)
                  | (wr_pend ? d_bus[7:0] : 8'h00);

  assign wr_status = bus.io_write && (addr == IO_STATUS);
  assign wr_mask   = bus.io_write && (addr == IO_MASK);
  assign wr_pend   = bus.io_write && (addr == IO_PEND);
  assign wr_gpio   = bus.io_write && (addr == IO_GPIO_OUT);

  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == RCW'(RAS_DEPTH));
  assign ras_top_idx = ras_sp - 1'b1;
  assign ras_top     = ras_empty ? 16'h0000 : ras_mem[ras_top_idx];
  assign ras_pop     = (rd_sel == RD_RAS);
  assign ras_pop_ok  = ras_pop & ~ras_empty;

  always_comb begin
    status                     = '0;
    status[4:0]                = 5'(fifo_count);
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_RAS_CNT +: 3]    = 3'(ras_count);
    status[ST_FIFO_OVF]        = fifo_ovf;
    status[ST_RAS_OVF]         = ras_ovf;
    status[ST_RAS_UNF]         = ras_unf;
    status[ST_IRQ]             = irq_pending;
  end

  always_comb begin
    reg_data = 16'h0000;
    case (addr)
      IO_STATUS:   reg_data = status;
      IO_MASK:     reg_data = {8'h00, mask};
      IO_PEND:     reg_data = {8'h00, pend};
      IO_GPIO_OUT: reg_data = gpio_out;
      IO_GPIO_IN:  reg_data = gpio_in_q;
      default:     reg_data = 16'h0000;
    endcase
  end

  always_comb begin
    rd_data = 16'h0000;
    case (rd_sel)
      RD_INTS: rd_data = (|active) ? (IRQ_VALID | 16'(vec)) : IRQ_NONE;
      RD_RAS:  rd_data = ras_top;
      RD_REG:  rd_data = reg_data;
      default: rd_data = 16'h0000;
    endcase
  end

  // dev_data/dev_valid follow valid/ready: a word leaves when both are high at the edge.
  assign dev_valid = ~fifo_empty;
  assign fifo_pop  = dev_valid & dev_ready;

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.io_push),
    .pop   (fifo_pop),
    .wdata (d_bus),
    .rdata (dev_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    gpio_in_q <= gpio_in;
  end

  // Sticky flags: a new event in the same cycle beats a write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      sync3       <= '0;
      pend        <= '0;
      mask        <= '0;
      irq_pending <= 1'b0;
      gpio_out    <= '0;
      fifo_ovf    <= 1'b0;
      ras_ovf     <= 1'b0;
      ras_unf     <= 1'b0;
      ras_sp      <= '0;
      ras_count   <= '0;
    end else begin
      sync1       <= irq_in;
      sync2       <= sync1;
      sync3       <= sync2;
      pend        <= (pend & ~pend_clr) | pend_set;
      irq_pending <= |active;
      if (wr_mask) mask     <= d_bus[7:0];
      if (wr_gpio) gpio_out <= d_bus;
      fifo_ovf <= (fifo_ovf & ~(wr_status & d_bus[ST_FIFO_OVF]))
                | (bus.io_push & fifo_full & ~fifo_pop);
      ras_ovf  <= (ras_ovf & ~(wr_status & d_bus[ST_RAS_OVF]))
                | (bus.io_store_retaddr & ras_full & ~ras_pop_ok);
      ras_unf  <= (ras_unf & ~(wr_status & d_bus[ST_RAS_UNF])) | (ras_pop & ras_empty);
      // Store while full overwrites the oldest slot, which is the one at ras_sp.
      if (bus.io_store_retaddr && ras_pop_ok) begin
        ras_mem[ras_top_idx] <= d_bus;
      end else if (bus.io_store_retaddr) begin
        ras_mem[ras_sp] <= d_bus;
        ras_sp          <= ras_sp + 1'b1;
        if (!ras_full) ras_count <= ras_count + 1'b1;
      end else if (ras_pop_ok) begin
        ras_sp    <= ras_top_idx;
        ras_count <= ras_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed scenarios plus random traffic against a queue-based reference model.
module tb_io_responder;
  import io_responder_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int RAS_DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_responder_if ifc();
  wire  [15:0] d_bus;
  logic [15:0] tb_data;
  logic [7:0]  irq_in;
  logic        irq_pending;
  logic [15:0] dev_data;
  logic        dev_valid;
  logic        dev_ready;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in;

  // Bench owns the bus whenever no read-type strobe is raised.
  assign d_bus = (ifc.io_ints | ifc.io_read_retaddr | ifc.io_read) ? 16'hzzzz : tb_data;

  io_responder #(.FIFO_DEPTH(FIFO_DEPTH), .RAS_DEPTH(RAS_DEPTH), .NUM_IRQ(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .d_bus       (d_bus),
    .irq_in      (irq_in),
    .irq_pending (irq_pending),
    .dev_data    (dev_data),
    .dev_valid   (dev_valid),
    .dev_ready   (dev_ready),
    .gpio_out    (gpio_out),
    .gpio_in     (gpio_in)
  );

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  logic [15:0] ras_q[$];
  logic        m_fovf, m_rovf, m_runf, m_irqp;
  logic [7:0]  m_mask, m_pend;
  logic [15:0] m_gpio_out, m_gpio_in_q;
  logic [7:0]  past [1:3];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s       = 16'h0000;
    s[4:0]  = 5'(exp_q.size());
    s[5]    = (exp_q.size() == FIFO_DEPTH);
    s[6]    = (exp_q.size() == 0);
    s[9:7]  = 3'(ras_q.size());
    s[10]   = m_fovf;
    s[11]   = m_rovf;
    s[12]   = m_runf;
    s[13]   = m_irqp;
    return s;
  endfunction

  function automatic logic [15:0] exp_read();
    logic [7:0] act;
    act = m_pend & m_mask;
    if (ifc.io_ints) begin
      for (int i = 0; i < 8; i++) if (act[i]) return IRQ_VALID | 16'(i);
      return IRQ_NONE;
    end
    if (ifc.io_read_retaddr) return (ras_q.size() > 0) ? ras_q[$] : 16'h0000;
    if (ifc.io_read) begin
      case (ifc.d_addr[3:0])
        IO_STATUS:   return exp_status();
        IO_MASK:     return {8'h00, m_mask};
        IO_PEND:     return {8'h00, m_pend};
        IO_GPIO_OUT: return m_gpio_out;
        IO_GPIO_IN:  return m_gpio_in_q;
        default:     return 16'h0000;
      endcase
    end
    return 16'h0000;
  endfunction

  task automatic model_edge();
    logic [7:0]  act, clr;
    logic [15:0] bus_v;
    logic        rd_act, do_pop, was_full;
    if (!rst_n) begin
      exp_q.delete();
      ras_q.delete();
      {m_fovf, m_rovf, m_runf, m_irqp} = 4'b0;
      m_mask = 8'h00; m_pend = 8'h00; m_gpio_out = 16'h0000;
      past[1] = 8'h00; past[2] = 8'h00; past[3] = 8'h00;
    end else begin
      rd_act = ifc.io_ints | ifc.io_read_retaddr | ifc.io_read;
      bus_v  = rd_act ? exp_read() : tb_data;
      act    = m_pend & m_mask;
      clr    = 8'h00;
      if (ifc.io_ints) begin
        for (int i = 0; i < 8; i++) if (act[i] && clr == 8'h00) clr[i] = 1'b1;
      end
      if (ifc.io_write) begin
        case (ifc.d_addr[3:0])
          IO_STATUS: begin
            if (bus_v[10]) m_fovf = 1'b0;
            if (bus_v[11]) m_rovf = 1'b0;
            if (bus_v[12]) m_runf = 1'b0;
          end
          IO_MASK:     m_mask = bus_v[7:0];
          IO_PEND:     clr = clr | bus_v[7:0];
          IO_GPIO_OUT: m_gpio_out = bus_v;
          default: ;
        endcase
      end
      // edge seen at sample e-2 but not at e-3 reaches PEND now
      m_pend = (m_pend & ~clr) | (past[2] & ~past[3]);
      m_irqp = |act;
      do_pop   = (exp_q.size() > 0) && dev_ready;
      was_full = (exp_q.size() == FIFO_DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (ifc.io_push) begin
        if (was_full && !do_pop) m_fovf = 1'b1;
        else exp_q.push_back(bus_v);
      end
      if (!ifc.io_ints && ifc.io_read_retaddr) begin
        if (ras_q.size() > 0) void'(ras_q.pop_back());
        else m_runf = 1'b1;
      end
      if (ifc.io_store_retaddr) begin
        if (ras_q.size() == RAS_DEPTH) begin
          void'(ras_q.pop_front());
          m_rovf = 1'b1;
        end
        ras_q.push_back(bus_v);
      end
      past[3] = past[2]; past[2] = past[1]; past[1] = irq_in;
    end
    m_gpio_in_q = gpio_in;
  endtask

  task automatic check_outputs();
    logic rd_act;
    rd_act = ifc.io_ints | ifc.io_read_retaddr | ifc.io_read;
    check_eq("dev_valid", 16'(dev_valid), 16'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_eq("dev_data", dev_data, exp_q[0]);
    check_eq("gpio_out", gpio_out, m_gpio_out);
    check_eq("irq_pending", 16'(irq_pending), 16'(m_irqp));
    check_eq("bus_drive", 16'(ifc.bus_drive), 16'(rd_act));
    if (rd_act) check_eq("d_bus_read", d_bus, exp_read());
    else        check_eq("d_bus_idle", d_bus, tb_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    ifc.io_read = 1'b0; ifc.io_write = 1'b0; ifc.io_push = 1'b0;
    ifc.io_ints = 1'b0; ifc.io_store_retaddr = 1'b0; ifc.io_read_retaddr = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] v);
    idle(); ifc.io_write = 1'b1; ifc.d_addr = 16'(a); tb_data = v;
    cyc(); idle();
  endtask

  task automatic do_read(input logic [3:0] a, input string tag, input logic [15:0] exp);
    idle(); ifc.io_read = 1'b1; ifc.d_addr = 16'(a);
    settle(); check_eq(tag, d_bus, exp); tick(); idle();
  endtask

  task automatic do_ints(input string tag, input logic [15:0] exp);
    idle(); ifc.io_ints = 1'b1;
    settle(); check_eq(tag, d_bus, exp); tick(); idle();
  endtask

  task automatic do_rret(input string tag, input logic [15:0] exp);
    idle(); ifc.io_read_retaddr = 1'b1;
    settle(); check_eq(tag, d_bus, exp); tick(); idle();
  endtask

  task automatic do_push(input logic [15:0] v);
    idle(); ifc.io_push = 1'b1; tb_data = v; cyc(); idle();
  endtask

  task automatic do_store(input logic [15:0] v);
    idle(); ifc.io_store_retaddr = 1'b1; tb_data = v; cyc(); idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    ifc.d_addr = 16'h0000; tb_data = 16'h0000; irq_in = 8'h00;
    dev_ready = 1'b0; gpio_in = 16'h5A5A;
    repeat (2) tick();
    rst_n = 1'b1;

    // reset state and basic register access
    check_eq("rst_dev_data", dev_data, 16'h0000);
    check_eq("rst_gpio_out", gpio_out, 16'h0000);
    do_read(IO_STATUS, "rst_status", 16'h0040);
    do_write(IO_MASK, 16'h00FF);
    do_read(IO_MASK, "mask_rd", 16'h00FF);
    do_read(4'd7, "unmapped_rd", 16'h0000);
    do_read(IO_GPIO_IN, "gpio_in_rd", 16'h5A5A);
    tb_data = 16'hC3C3;
    settle(); check_eq("idle_no_drive", 16'(ifc.bus_drive), 16'h0000); tick();

    // fill and overflow the FIFO, then drain
    for (int i = 0; i < 9; i++) do_push(16'h1000 + 16'(i));
    do_read(IO_STATUS, "fifo_full_status", 16'h0428);
    dev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle(); check_eq("drain_data", dev_data, 16'h1000 + 16'(i)); tick();
    end
    settle(); check_eq("drain_empty", 16'(dev_valid), 16'h0000); tick();
    dev_ready = 1'b0;
    do_write(IO_STATUS, 16'h0400);

    // interrupts: lowest unmasked pending wins, acknowledge clears it
    do_write(IO_MASK, 16'h000C);
    irq_in = 8'h08; cyc();
    irq_in = 8'h04; cyc();
    irq_in = 8'h00;
    repeat (4) cyc();
    check_eq("irq_pending_set", 16'(irq_pending), 16'h0001);
    do_ints("vec_2", 16'h8002);
    do_ints("vec_3", 16'h8003);
    do_ints("vec_none", 16'h0000);
    settle(); check_eq("irq_pending_clr", 16'(irq_pending), 16'h0000); tick();

    // return-address stack overflow and underflow
    for (int i = 1; i <= 5; i++) do_store(16'h00A0 + 16'(i));
    do_read(IO_STATUS, "ras_ovf_status", 16'h0A40);
    for (int i = 5; i >= 2; i--) do_rret("ras_pop", 16'h00A0 + 16'(i));
    do_rret("ras_unf_pop", 16'h0000);
    do_read(IO_STATUS, "ras_unf_status", 16'h1840);
    do_write(IO_STATUS, 16'h1C00);

    // push and pop together while full
    for (int i = 0; i < 8; i++) do_push(16'h2000 + 16'(i));
    idle(); ifc.io_push = 1'b1; tb_data = 16'h2008; dev_ready = 1'b1;
    settle(); check_eq("full_pushpop_head", dev_data, 16'h2000); tick();
    idle(); dev_ready = 1'b0;
    do_read(IO_STATUS, "full_pushpop_status", 16'h0028);
    dev_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      settle(); check_eq("order_after_pushpop", dev_data, 16'h2000 + 16'(i)); tick();
    end
    dev_ready = 1'b0;

    // reset in the middle of traffic
    do_push(16'h3000);
    do_push(16'h3001);
    irq_in = 8'hFF; cyc();
    idle(); ifc.io_push = 1'b1; tb_data = 16'h3002; irq_in = 8'h0F; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; irq_in = 8'h00; idle();
    ifc.io_read = 1'b1; ifc.d_addr = 16'(IO_PEND);
    settle();
    check_eq("post_rst_valid", 16'(dev_valid), 16'h0000);
    check_eq("post_rst_pend", d_bus, 16'h0000);
    tick(); idle();
    do_read(IO_STATUS, "post_rst_status", 16'h0040);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      idle();
      r         = $urandom_range(0, 9);
      tb_data   = 16'($urandom);
      gpio_in   = 16'($urandom);
      dev_ready = ($urandom_range(0, 3) == 0);
      ifc.d_addr = {4'($urandom), 8'($urandom), 4'($urandom_range(0, 7))};
      ifc.io_push          = ($urandom_range(0, 2) == 0);
      ifc.io_store_retaddr = ($urandom_range(0, 3) == 0);
      case (r)
        0: ifc.io_read = 1'b1;
        1: ifc.io_read_retaddr = 1'b1;
        2: ifc.io_ints = 1'b1;
        3: begin ifc.io_ints = 1'b1; ifc.io_read_retaddr = 1'b1; end
        4: begin ifc.io_read_retaddr = 1'b1; ifc.io_read = 1'b1; end
        default: ifc.io_write = ($urandom_range(0, 2) == 0);
      endcase
      if ($urandom_range(0, 4) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
      cyc();
    end

    idle();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
